ro_period_counter: RTL and testbench

- Read-out end of the NAND-based ring oscillator built from the gf180mcu OSU 9T cells. Used for temperature-sensor and cell-delay characterisation.
- Samples the slow, asynchronous oscillator output in the CLK_REF domain.
- Counts CLK_REF cycles spanning 2^SEL_CONV_TIME oscillator periods and presents the result with a DONE flag.
- Sits between the analog ring-oscillator macro and the digital scan/readout register.

---
 rtl/ro_period_counter_pkg.sv | 23 ++
 rtl/ro_period_counter_sync.sv | 27 ++
 rtl/ro_period_counter.sv | 122 ++++++++++++
 tb/tb_ro_period_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_period_counter_pkg.sv
// rtl/ro_period_counter_pkg.sv - shared state type, default widths and constant helpers for the ring-oscillator period counter
package ro_period_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } ro_state_t;

    localparam int DEF_DOUT_W = 24;
    localparam int DEF_SEL_W  = 4;
    localparam int DEF_TO_W   = 16;

    // All-ones value of a w-bit counter; callers cast down to their own width.
    function automatic logic [31:0] sat_max(input int w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/ro_period_counter_sync.sv
// rtl/ro_period_counter_sync.sv - two-flop synchroniser plus history flop giving a one-cycle rising-edge pulse
module ro_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/ro_period_counter.sv
// rtl/ro_period_counter.sv - counts CLK_REF cycles across 2^SEL_CONV_TIME ring-oscillator periods
module ro_period_counter
    import ro_period_counter_pkg::*;
#(
    parameter int DOUT_W = DEF_DOUT_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int TO_W   = DEF_TO_W
) (
    input  logic              CLK_REF,
    input  logic              RESET_COUNTERn,
    input  logic              start,
    input  logic [SEL_W-1:0]  SEL_CONV_TIME,
    input  logic              osc_in,
    output logic [DOUT_W-1:0] DOUT,
    output logic              DONE,
    output logic              OVF,
    output logic              TIMEOUT,
    output logic              busy
);

    localparam int PER_W = (2 ** SEL_W) - 1;
    localparam logic [DOUT_W-1:0] REF_MAX = DOUT_W'(sat_max(DOUT_W));
    // Compare against max-1 so the abort lands on the cycle the counter would reach max.
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(sat_max(TO_W) - 32'd1);

    ro_state_t          state;
    logic [SEL_W-1:0]   sel_q;
    logic [DOUT_W-1:0]  ref_cnt;
    logic [PER_W-1:0]   per_cnt;
    logic [TO_W-1:0]    tmo_cnt;
    logic               osc_edge;

    logic [DOUT_W-1:0]  ref_inc;
    logic               ref_sat;
    logic [PER_W:0]     per_next;
    logic [PER_W:0]     per_goal;

    ro_sync_edge u_sync (
        .clk      (CLK_REF),
        .rst_n    (RESET_COUNTERn),
        .async_in (osc_in),
        .rise     (osc_edge)
    );

    assign ref_sat  = (ref_cnt == REF_MAX);
    assign ref_inc  = ref_sat ? REF_MAX : ref_cnt + DOUT_W'(1);
    // One extra bit so the terminal compare never sees a wrapped period count.
    assign per_next = {1'b0, per_cnt} + (PER_W + 1)'(1);
    assign per_goal = (PER_W + 1)'(1) << sel_q;

    always_ff @(posedge CLK_REF or negedge RESET_COUNTERn) begin
        if (!RESET_COUNTERn) begin
            state   <= ST_IDLE;
            sel_q   <= '0;
            ref_cnt <= '0;
            per_cnt <= '0;
            tmo_cnt <= '0;
            DOUT    <= '0;
            DONE    <= 1'b0;
            OVF     <= 1'b0;
            TIMEOUT <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sel_q   <= SEL_CONV_TIME;
                        OVF     <= 1'b0;
                        TIMEOUT <= 1'b0;
                        DONE    <= 1'b0;
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (osc_edge) begin
                        ref_cnt <= '0;
                        per_cnt <= '0;
                        tmo_cnt <= '0;
                        state   <= ST_MEASURE;
                    end else if (tmo_cnt == TO_LAST) begin
                        DOUT    <= '0;
                        TIMEOUT <= 1'b1;
                        DONE    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TO_W'(1);
                    end
                end
                ST_MEASURE: begin
                    ref_cnt <= ref_inc;
                    if (ref_sat) begin
                        OVF <= 1'b1;
                    end
                    // An edge on the timeout terminal cycle still counts as oscillator activity.
                    if (osc_edge) begin
                        tmo_cnt <= '0;
                        per_cnt <= per_next[PER_W-1:0];
                        if (per_next == per_goal) begin
                            DOUT  <= ref_inc;
                            DONE  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end
                    end else if (tmo_cnt == TO_LAST) begin
                        DOUT    <= '0;
                        TIMEOUT <= 1'b1;
                        DONE    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TO_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_period_counter.sv
// tb/tb_ro_period_counter.sv - randomized self-checking bench for ro_period_counter against an edge-list reference model
module tb_ro_period_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       osc;
    logic [3:0] sel;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] dout_a, dout_t;
    logic [7:0]  dout_o;
    logic done_a, done_t, done_o, ovf_a, ovf_t, ovf_o;
    logic tmo_a, tmo_t, tmo_o, busy_a, busy_t, busy_o;

    ro_period_counter u_main (
        .CLK_REF(clk), .RESET_COUNTERn(rst_n), .start(start), .SEL_CONV_TIME(sel), .osc_in(osc),
        .DOUT(dout_a), .DONE(done_a), .OVF(ovf_a), .TIMEOUT(tmo_a), .busy(busy_a)
    );

    ro_period_counter #(.TO_W(6)) u_short_to (
        .CLK_REF(clk), .RESET_COUNTERn(rst_n), .start(start), .SEL_CONV_TIME(sel), .osc_in(osc),
        .DOUT(dout_t), .DONE(done_t), .OVF(ovf_t), .TIMEOUT(tmo_t), .busy(busy_t)
    );

    ro_period_counter #(.DOUT_W(8)) u_narrow (
        .CLK_REF(clk), .RESET_COUNTERn(rst_n), .start(start), .SEL_CONV_TIME(sel), .osc_in(osc),
        .DOUT(dout_o), .DONE(done_o), .OVF(ovf_o), .TIMEOUT(tmo_o), .busy(busy_o)
    );

    logic [31:0] g_dout [3];
    logic        g_done [3];
    logic        g_ovf  [3];
    logic        g_tmo  [3];
    logic        g_busy [3];

    assign g_dout[0] = 32'(dout_a);
    assign g_dout[1] = 32'(dout_t);
    assign g_dout[2] = 32'(dout_o);
    assign g_done[0] = done_a;
    assign g_done[1] = done_t;
    assign g_done[2] = done_o;
    assign g_ovf[0]  = ovf_a;
    assign g_ovf[1]  = ovf_t;
    assign g_ovf[2]  = ovf_o;
    assign g_tmo[0]  = tmo_a;
    assign g_tmo[1]  = tmo_t;
    assign g_tmo[2]  = tmo_o;
    assign g_busy[0] = busy_a;
    assign g_busy[1] = busy_t;
    assign g_busy[2] = busy_o;

    int to_max [3] = '{65535, 63, 65535};
    int d_max  [3] = '{16777215, 16777215, 255};

    int n_total = 0;
    int n_bad   = 0;

    int rises[$];
    int hi_len;
    int exp_done [3];
    int exp_dout [3];
    bit exp_ovf  [3];
    bit exp_tmo  [3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit osc_at(input int c);
        foreach (rises[i]) begin
            if (c >= rises[i] && c < rises[i] + hi_len) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Walks the detected edges (two cycles after each rise reaches the input flop).
    task automatic model(input int cs, input int sel_v, input int tmax, input int dmax,
                         output int done, output int dout, output bit ovf, output bit tmo);
        int last;
        int first;
        int cnt;
        last  = cs;
        first = -1;
        cnt   = 0;
        foreach (rises[i]) begin
            int det;
            det = rises[i] + 2;
            if (det <= cs) continue;
            if (det - last > tmax) break;
            if (first < 0) begin
                first = det;
            end else begin
                cnt++;
                if (cnt == (1 << sel_v)) begin
                    dout = det - first;
                    ovf  = (dout > dmax);
                    if (ovf) dout = dmax;
                    tmo  = 1'b0;
                    done = det;
                    return;
                end
            end
            last = det;
        end
        done = last + tmax;
        dout = 0;
        tmo  = 1'b1;
        ovf  = (first >= 0) && ((done - first) > dmax);
    endtask

    task automatic check_reset_vals();
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("rst_dout%0d", k), g_dout[k], 32'd0);
            check_val($sformatf("rst_done%0d", k), 32'(g_done[k]), 32'd0);
            check_val($sformatf("rst_ovf%0d", k), 32'(g_ovf[k]), 32'd0);
            check_val($sformatf("rst_tmo%0d", k), 32'(g_tmo[k]), 32'd0);
            check_val($sformatf("rst_busy%0d", k), 32'(g_busy[k]), 32'd0);
        end
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        osc   = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_cycle(input int c);
        for (int k = 0; k < 3; k++) begin
            bit is_done;
            is_done = (c >= exp_done[k]);
            check_val($sformatf("done%0d", k), 32'(g_done[k]), 32'(is_done));
            check_val($sformatf("busy%0d", k), 32'(g_busy[k]), 32'(!is_done));
            if (is_done) begin
                check_val($sformatf("dout%0d", k), g_dout[k], 32'(exp_dout[k]));
                check_val($sformatf("ovf%0d", k), 32'(g_ovf[k]), 32'(exp_ovf[k]));
                check_val($sformatf("tmo%0d", k), 32'(g_tmo[k]), 32'(exp_tmo[k]));
            end else begin
                check_val($sformatf("tmo_early%0d", k), 32'(g_tmo[k]), 32'd0);
            end
        end
    endtask

    task automatic run_test(input int p, input int sel_v, input int n_r, input int stray, input int abort_at);
        int cs;
        int r0;
        int mx;
        int end_c;
        bit pending;
        @(negedge clk);
        cs    = cyc + 1;
        start = 1'b1;
        sel   = 4'(sel_v);
        osc   = 1'b0;
        rises.delete();
        hi_len = p / 2;
        r0 = cs + 3 + int'($urandom_range(0, 5));
        for (int i = 0; i < n_r; i++) rises.push_back(r0 + i * p);
        mx = cs;
        for (int k = 0; k < 3; k++) begin
            model(cs, sel_v, to_max[k], d_max[k], exp_done[k], exp_dout[k], exp_ovf[k], exp_tmo[k]);
            mx = (exp_done[k] > mx) ? exp_done[k] : mx;
        end
        if (mx > cs + 700) mx = cs + 700;
        if (n_r > 0 && rises[n_r - 1] + p > mx) mx = rises[n_r - 1] + p;
        end_c = (abort_at > 0) ? cs + abort_at : mx + 2;
        while (cyc < end_c) begin
            if (cyc >= cs) check_cycle(cyc);
            start = (cyc + 1 == cs) || (stray > 0 && cyc + 1 == cs + stray);
            if (cyc + 1 != cs) sel = 4'($urandom);
            osc = osc_at(cyc + 1);
            @(negedge clk);
        end
        pending = (abort_at > 0);
        for (int k = 0; k < 3; k++) if (exp_done[k] > cyc) pending = 1'b1;
        if (pending) async_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        osc   = 1'b0;
        sel   = 4'd0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        run_test(10, 0, 3, 0, 0);
        run_test(10, 3, 9, 30, 0);
        run_test(40, 3, 9, 0, 0);
        run_test(10, 3, 9, 0, 40);
        run_test(7, 1, 3, 0, 0);
        run_test(10, 2, 0, 0, 0);
        run_test(10, 3, 4, 0, 0);
        run_test(63, 0, 2, 0, 0);
        run_test(64, 0, 2, 0, 0);

        for (int t = 0; t < 15; t++) begin
            int p;
            int s;
            int n;
            p = int'($urandom_range(4, 70));
            s = int'($urandom_range(0, 3));
            n = (1 << s) + 1;
            if ($urandom_range(0, 4) == 0) n = int'($urandom_range(0, n - 1));
            run_test(p, s, n, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
